// File: rtl/ysyx_22041207_div.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned, 64-bit and word forms.
// Divide-by-zero and signed overflow skip the iteration and complete one cycle after accept.
module ysyx_22041207_div #(
  parameter int XLEN = 64,
  parameter int ITER = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid,
  input  logic            flush,
  input  logic            div_signed,
  input  logic            divw,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] a_ext, b_ext, a_sx, a_mag, b_mag;
  logic            a_neg, b_neg, b_zero, ovf, special;
  logic [XLEN-1:0] spec_q, spec_r;

  logic [XLEN-1:0] quo_r, rem_r, dvs_r;
  logic            neg_q_r, neg_r_r, word_r, special_r;
  logic [CW-1:0]   cnt;

  logic [XLEN:0]   r_sh, r_sub;
  logic [XLEN-1:0] q_step, r_step, q_sgn, r_sgn, q_fin, r_fin;
  logic            accept, last_iter, load_out;

  // Operand preparation: select width, extend, and take magnitudes for signed ops.
  always_comb begin
    if (divw) begin
      a_ext = {{HW{div_signed & dividend[HW-1]}}, dividend[HW-1:0]};
      b_ext = {{HW{div_signed & divisor[HW-1]}}, divisor[HW-1:0]};
      a_sx  = {{HW{dividend[HW-1]}}, dividend[HW-1:0]};
      ovf   = div_signed & dividend[HW-1] & ~|dividend[HW-2:0] & (&divisor[HW-1:0]);
    end else begin
      a_ext = dividend;
      b_ext = divisor;
      a_sx  = dividend;
      ovf   = div_signed & dividend[XLEN-1] & ~|dividend[XLEN-2:0] & (&divisor);
    end
    a_neg   = div_signed & a_ext[XLEN-1];
    b_neg   = div_signed & b_ext[XLEN-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    b_zero  = (b_ext == '0);
    special = b_zero | ovf;
    // Special results are already in final (sign-extended) form.
    spec_q  = b_zero ? '1 : a_sx;
    spec_r  = b_zero ? a_sx : '0;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_sh   = {rem_r, quo_r[XLEN-1]};
    r_sub  = r_sh - {1'b0, dvs_r};
    q_step = {quo_r[XLEN-2:0], ~r_sub[XLEN]};
    r_step = r_sub[XLEN] ? r_sh[XLEN-1:0] : r_sub[XLEN-1:0];
    q_sgn  = neg_q_r ? -q_step : q_step;
    r_sgn  = neg_r_r ? -r_step : r_step;
    if (special_r) begin
      q_fin = quo_r;
      r_fin = rem_r;
    end else if (word_r) begin
      q_fin = {{HW{q_sgn[HW-1]}}, q_sgn[HW-1:0]};
      r_fin = {{HW{r_sgn[HW-1]}}, r_sgn[HW-1:0]};
    end else begin
      q_fin = q_sgn;
      r_fin = r_sgn;
    end
  end

  assign div_ready = (state == IDLE);
  assign accept    = (state == IDLE) && div_valid && !flush;
  assign last_iter = (cnt == CW'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (div_valid && !flush) state_nxt = CALC;
      CALC: begin
        if (flush)                       state_nxt = IDLE;
        else if (special_r || last_iter) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load_out = (state == CALC) && (state_nxt == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        cnt       <= '0;
        special_r <= special;
        word_r    <= divw;
        neg_q_r   <= (a_neg ^ b_neg) & ~b_zero;
        neg_r_r   <= a_neg;
        dvs_r     <= b_mag;
        quo_r     <= special ? spec_q : a_mag;
        rem_r     <= special ? spec_r : '0;
      end else if (state == CALC && !special_r) begin
        quo_r <= q_step;
        rem_r <= r_step;
        cnt   <= cnt + 1'b1;
      end
      if (load_out) begin
        quotient  <= q_fin;
        remainder <= r_fin;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_div.sv
// Randomized and directed bench for ysyx_22041207_div against an arithmetic reference model.
module tb_ysyx_22041207_div;

  logic        clk = 1'b0, rst = 1'b1;
  logic        div_valid = 1'b0, flush = 1'b0, div_signed = 1'b0, divw = 1'b0;
  logic [63:0] dividend = '0, divisor = '0;
  logic        div_ready, out_valid;
  logic [63:0] quotient, remainder;

  ysyx_22041207_div dut (
    .clk(clk), .rst(rst), .div_valid(div_valid), .flush(flush),
    .div_signed(div_signed), .divw(divw), .dividend(dividend), .divisor(divisor),
    .div_ready(div_ready), .out_valid(out_valid), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0, cyc = 0;
  logic        exp_pending = 1'b0, chk_ready = 1'b0, mon_en = 1'b0;
  logic [63:0] exp_q = '0, exp_r = '0, last_q = '0, last_r = '0;
  int          exp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain language arithmetic with the special cases spelled out.
  function automatic void model(input logic s, input logic w, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] q,
                                output logic [63:0] r, output int lat);
    logic [31:0] a32, b32, q32, r32;
    lat = 64;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32; lat = 1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = '0; lat = 1;
      end else if (s) begin
        q32 = 32'($signed(a32) / $signed(b32));
        r32 = 32'($signed(a32) % $signed(b32));
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a; lat = 1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0; lat = 1;
      end else if (s) begin
        q = 64'($signed(a) / $signed(b));
        r = 64'($signed(a) % $signed(b));
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Single compare process: result timing, values, hold and ready behaviour.
  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_ready) begin
        check_int("ready_after_done", int'(div_ready), 1);
        chk_ready = 1'b0;
      end
      if (out_valid) begin
        if (!exp_pending) begin
          check_int("spurious_out_valid", int'(out_valid), 0);
        end else begin
          check_int("latency", cyc, exp_cyc);
          check64("quotient", quotient, exp_q);
          check64("remainder", remainder, exp_r);
          last_q = exp_q;
          last_r = exp_r;
          exp_pending = 1'b0;
          chk_ready = 1'b1;
        end
      end else begin
        check64("hold_quotient", quotient, last_q);
        check64("hold_remainder", remainder, last_r);
        if (exp_pending) begin
          check_int("busy_not_ready", int'(div_ready), 0);
          if (cyc > exp_cyc) begin
            check_int("result_timeout", cyc, exp_cyc);
            exp_pending = 1'b0;
          end
        end
      end
    end
  end

  // Caller is at a negedge; issues one request and returns just after its accept edge.
  task automatic do_op(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mq, mr;
    int lat, n;
    model(s, w, a, b, mq, mr, lat);
    n = 0;
    while (!div_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!div_ready) begin
      check_int("ready_timeout", int'(div_ready), 1);
      return;
    end
    div_valid = 1'b1; div_signed = s; divw = w; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    exp_q = mq; exp_r = mr; exp_cyc = cyc + lat; exp_pending = 1'b1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exp_pending && n < 200);
  endtask

  task automatic op_lit(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] lq, input logic [63:0] lr, input int llat);
    logic [63:0] mq, mr;
    int lat;
    model(s, w, a, b, mq, mr, lat);
    check64("model_pin_q", mq, lq);
    check64("model_pin_r", mr, lr);
    check_int("model_pin_lat", lat, llat);
    do_op(s, w, a, b);
    wait_done();
  endtask

  initial begin
    logic [63:0] a, b;
    logic s, w;
    int mode;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check64("reset_quotient", quotient, 64'd0);
    check64("reset_remainder", remainder, 64'd0);
    check_int("reset_out_valid", int'(out_valid), 0);
    check_int("reset_ready", int'(div_ready), 1);
    mon_en = 1'b1;

    op_lit(0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 64);
    op_lit(1, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    op_lit(1, 0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64);
    op_lit(1, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
    op_lit(0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
    op_lit(1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 64'd0, 1);
    op_lit(1, 1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 64'd0, 1);
    op_lit(0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64);

    // Flush mid-iteration, then an immediate new request.
    do_op(0, 0, 64'd100, 64'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    exp_pending = 1'b0;
    @(negedge clk);
    check_int("ready_after_flush", int'(div_ready), 1);
    do_op(0, 0, 64'd100, 64'd7);
    wait_done();

    // Flush beats a same-edge request.
    @(negedge clk);
    div_valid = 1'b1; dividend = 64'd9; divisor = 64'd3; div_signed = 1'b0; divw = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; div_valid = 1'b0; end
    @(negedge clk);
    check_int("flush_blocks_accept", int'(div_ready), 1);

    // Reset mid-operation clears the outputs.
    do_op(1, 0, 64'd12345, -64'sd17);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 begin rst = 1'b0; exp_pending = 1'b0; last_q = '0; last_r = '0; end
    @(negedge clk);
    check_int("ready_after_rst", int'(div_ready), 1);
    check64("rst_quotient", quotient, 64'd0);
    check64("rst_remainder", remainder, 64'd0);

    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      mode = $urandom_range(0, 5);
      case (mode)
        1: b = (s && $urandom_range(0, 1) == 1) ? -64'($urandom_range(1, 1000))
                                                 : 64'($urandom_range(1, 1000));
        2: b = w ? {b[63:32], 32'd0} : 64'd0;
        3: begin
          if (w) begin a[31:0] = 32'h8000_0000; b[31:0] = 32'hFFFF_FFFF; end
          else begin a = 64'h8000_0000_0000_0000; b = '1; end
        end
        4: a = 64'($urandom_range(0, 50));
        5: begin a = -64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 20)); end
        default: ;
      endcase
      do_op(s, w, a, b);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
